// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage for the 4-bit accumulator core. Holds a small
// writable program memory and the program counter, presents one instruction
// at a time over a valid/ready handshake, accepts jump redirects from the
// core's branch logic and stops for good once a halt opcode is consumed.
//
// Parameters:
//   IMEM_DEPTH  program memory entries (must equal 2**PC_W)
//   PC_W        program counter width
//   INSTR_W     instruction width; top 4 bits opcode, low bits immediate
//   HALT_OP     opcode that halts fetch
//
// Ports:
//   clk          single clock, all state updates on the rising edge
//   reset        asynchronous, active-high reset
//   run          level-sensitive fetch enable
//   prog_we      program memory write strobe (honoured only in IDLE/HALT)
//   prog_addr    program memory write address
//   prog_data    program memory write data
//   instr        instruction presented to the core
//   instr_pc     address that instr was fetched from
//   instr_valid  instr is valid
//   instr_ready  core accepts instr
//   jmp_en       redirect request from the core
//   jmp_addr     redirect target
//   pc           current program counter (next or current fetch address)
//   halted       halt opcode has been consumed
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter int unsigned IMEM_DEPTH = 16,
  parameter int unsigned PC_W       = 4,
  parameter int unsigned INSTR_W    = 8,
  parameter logic [3:0]  HALT_OP    = 4'hF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               jmp_en,
  input  logic [PC_W-1:0]    jmp_addr,
  output logic [PC_W-1:0]    pc,
  output logic               halted
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_VALID,
    S_HALT
  } state_e;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               halted_q, halted_d;

  logic [INSTR_W-1:0] mem [IMEM_DEPTH];
  logic [INSTR_W-1:0] rdata_q;

  logic               rd_en;
  logic               wr_en;
  logic               accept;
  logic               is_halt;

  // valid_q is only ever set in VALID, so the handshake alone identifies
  // a transfer; ready while nothing is valid does nothing.
  assign accept  = valid_q && instr_ready;
  assign is_halt = (instr_q[INSTR_W-1 -: 4] == HALT_OP);

  // Program writes are only safe when no fetch can be in flight.
  assign wr_en = prog_we && ((state_q == S_IDLE) || (state_q == S_HALT));

  // Next-state logic. Every transition into FETCH raises rd_en, and the
  // memory is addressed with pc_d, so the read for the new fetch address
  // is issued on the same edge that enters FETCH and its data is ready
  // for capture on the following edge.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_pc_d = instr_pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    halted_d   = halted_q;
    rd_en      = 1'b0;

    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        if (run) begin
          rd_en   = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        if (jmp_en) begin
          // Redirect: the read already in flight is simply never captured.
          pc_d = jmp_addr;
          if (run) begin
            rd_en   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          instr_d    = rdata_q;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          state_d    = S_VALID;
        end
      end

      S_VALID: begin
        if (accept && is_halt) begin
          // A consumed halt beats a simultaneous jump; pc stays put.
          valid_d  = 1'b0;
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else if (jmp_en || accept) begin
          // A jump overrides the sequential increment, whether or not the
          // presented instruction was consumed on this edge.
          pc_d    = jmp_en ? jmp_addr : (pc_q + PC_ONE);
          valid_d = 1'b0;
          if (run) begin
            rd_en   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_HALT: begin
        valid_d  = 1'b0;
        halted_d = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers; asynchronous reset clears the handshake
  // immediately so instr_valid can drop mid-cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      instr_pc_q <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_pc_q <= instr_pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
    end
  end

  // Program memory: contents survive reset, so it has no reset branch.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[prog_addr] <= prog_data;
    end
    if (rd_en) begin
      rdata_q <= mem[pc_d];
    end
  end

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign halted      = halted_q;

endmodule
